// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned LEN_W         = 16;
    localparam int unsigned ADDR_W        = 31;
    localparam int unsigned BYTE_IDX_W    = 2;
    localparam int unsigned MEM_WORDS_DEF = 256;

    localparam logic [BYTE_W-1:0] MAGIC_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_HI     = 3'd1,
        ST_LEN_LO     = 3'd2,
        ST_DATA       = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM       = 3'd4,
`endif
        ST_RUN        = 3'd5,
        ST_ERROR      = 3'd6
    } state_e;

    // Registered instruction-RAM write payload
    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } imem_wr_t;

    // Word index to word-aligned byte address, matching the fetch port
    function automatic logic [ADDR_W-1:0] word_addr(input logic [LEN_W-1:0] widx);
        return ADDR_W'(widx) << 2;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic               rx_valid;
    logic [BYTE_W-1:0]  rx_data;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word assembler; flags the byte that completes a word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               word_valid_c,
    output logic [DATA_W-1:0]  word_c
);

    localparam int unsigned SHIFT_W = DATA_W - BYTE_W;
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(DATA_W / BYTE_W - 1);

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [SHIFT_W-1:0]    shift_q;

    // Earlier bytes shift toward the MSB so the first byte lands in [31:24]
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid) begin
            idx_q   <= idx_q + BYTE_IDX_W'(1);
            shift_q <= {shift_q[SHIFT_W-BYTE_W-1:0], byte_data};
        end
    end

    assign word_valid_c = byte_valid && (idx_q == LAST_IDX);
    assign word_c       = {shift_q, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Boot sequencer: parses the framed UART image, writes instruction RAM, holds the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       MEM_WORDS = MEM_WORDS_DEF,
    parameter logic [BYTE_W-1:0] MAGIC     = MAGIC_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.master     bus,
    input  logic              boot_req,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
    localparam state_e ST_AFTER_DATA = ST_RUN;
`endif

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   widx_q, widx_d;
    imem_wr_t           wr_q, wr_d;
    logic [LEN_W-1:0]   len_rx_c;
    logic               pk_clear_c;
    logic               pk_valid_c;
    logic               word_valid_c;
    logic [DATA_W-1:0]  word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

    imem_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (pk_clear_c),
        .byte_valid   (pk_valid_c),
        .byte_data    (bus.rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    assign len_rx_c = {len_q[LEN_W-1:BYTE_W], bus.rx_data};

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        widx_d     = widx_q;
        wr_d       = wr_q;
        wr_d.we    = 1'b0;
        pk_clear_c = 1'b0;
        pk_valid_c = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_WAIT_MAGIC: begin
                if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
                    state_d = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d   = {bus.rx_data, len_q[BYTE_W-1:0]};
                    state_d = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d      = len_rx_c;
                    widx_d     = '0;
                    pk_clear_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    if (32'(len_rx_c) > MEM_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (len_rx_c == '0) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (bus.rx_valid) begin
                    pk_valid_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.rx_data;
`endif
                    if (word_valid_c) begin
                        wr_d.we    = 1'b1;
                        wr_d.addr  = word_addr(widx_q);
                        wr_d.wdata = word_c;
                        widx_d     = widx_q + LEN_W'(1);
                        if (widx_q == len_q - LEN_W'(1)) begin
                            state_d = ST_AFTER_DATA;
                        end
                    end
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == csum_q) ? ST_RUN : ST_ERROR;
                end
            end
`endif

            ST_RUN: begin
                if (boot_req) begin
                    state_d = ST_WAIT_MAGIC;
                end
            end

            ST_ERROR: begin
                if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
                    state_d = ST_LEN_HI;
                end
            end

            default: begin
                state_d = ST_WAIT_MAGIC;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT_MAGIC;
            len_q     <= '0;
            widx_q    <= '0;
            wr_q      <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            widx_q    <= widx_d;
            wr_q      <= wr_d;
            cpu_hold  <= (state_d != ST_RUN);
            load_done <= (state_d == ST_RUN);
            load_err  <= (state_d == ST_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign bus.mem_we    = wr_q.we;
    assign bus.mem_addr  = wr_q.addr;
    assign bus.mem_wdata = wr_q.wdata;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time sequencer for the single-cycle CPU's instruction memory. Receives a framed program image as a byte stream from the UART receiver, assembles big-endian 32-bit words, writes them into the instruction RAM and holds the CPU in stall until the image is complete. It sits between the UART RX path, the instruction-memory write port and the CPU hold input, and replaces the fixed ROM contents at run time.

## Interface
- MEM_WORDS, 256: instruction memory depth in words; images longer than this are rejected.
- MAGIC, 8'hA5: frame start byte.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- boot_req  in  1  request a reload; honoured only in RUN.
- mem_we  out  1  instruction RAM write strobe, one cycle per word.
- mem_addr  out  31  byte address, word-aligned (bits [1:0] = 0), same addressing as the instruction fetch port.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  1 = CPU stalled/held.
- load_done  out  1  level, 1 while in RUN after a successful load.
- load_err  out  1  level, 1 while in ERROR.

## Operation
- Frame: MAGIC, LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 data bytes (MSB first per word), then checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
- States: WAIT_MAGIC, LEN_HI, LEN_LO, DATA, CSUM (macro only), RUN, ERROR.
- WAIT_MAGIC: non-MAGIC bytes ignored; MAGIC -> LEN_HI.
- LEN_HI -> LEN_LO on next byte; LEN_LO latches N, clears word index and byte index.
- After LEN_LO: N > MEM_WORDS -> ERROR; N = 0 -> CSUM (macro) or RUN; else DATA.
- DATA: shift byte into 32-bit assembly register; on 4th byte issue write to word index w (mem_addr = w<<2), w++; after word N-1 -> CSUM or RUN.
- RUN: cpu_hold=0, load_done=1. boot_req=1 -> WAIT_MAGIC; bytes received in RUN ignored.
- ERROR: cpu_hold=1, load_err=1; MAGIC byte restarts (-> LEN_HI, load_err clears).
- boot_req outside RUN ignored. Bytes are consumed only on rx_valid; gaps of any length between bytes permitted (no timeout).
- Already written words are not rolled back on ERROR.

## Timing
- Reset: state WAIT_MAGIC, cpu_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_err=0, all counters 0. Reset mid-frame abandons the frame.
- mem_we/mem_addr/mem_wdata registered: asserted the cycle after rx_valid of a word's 4th byte, for exactly one cycle.
- State transitions take effect the cycle after the accepting rx_valid.
- cpu_hold falls the cycle after the last byte (final data byte or checksum), i.e. same cycle as the last mem_we; CPU's first fetch after release sees the written word.
- boot_req in RUN: cpu_hold=1 and load_done=0 from the next cycle.
- rx_valid back-to-back every cycle supported.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: XOR of all data bytes (not header) accumulated; CSUM state compares next byte; match -> RUN, mismatch -> ERROR. Writes still issued as words complete.
- Undefined: no CSUM state, no accumulator; last data byte -> RUN.

## Structure
- Shared package: state enum, MAGIC default, frame field widths (LEN 16 bits, address 31 bits).
- One sub-module natural: imem_word_packer (byte shift register + byte index, emits word_valid/word).

## Test plan
- Reset, send A5 00 02 then 8 bytes 3C 08 40 00 8D 09 00 20 -> mem_we at addr 0 data 32'h3C084000, addr 4 data 32'h8D090020; cpu_hold 1→0 with second write; load_done=1.
- Junk bytes 00 FF 12 before A5 00 01 + 4 bytes -> junk ignored, single write at addr 0.
- A5 01 01 with MEM_WORDS=256 -> ERROR, load_err=1, cpu_hold=1, no mem_we; then valid frame -> RUN.
- In RUN pulse boot_req -> cpu_hold=1 next cycle; send A5 00 00 -> RUN with no writes.
- Reset asserted after 2 data bytes -> WAIT_MAGIC, no write, counters 0; full frame afterwards loads from addr 0.
- Macro on: A5 00 01 12 34 56 78 + checksum 08 -> RUN; with checksum 09 -> ERROR, word still written.
